// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard control for the 5-stage RV32I core: stalls, flushes, forwarding,
// multi-cycle MDU handshake, data-memory watchdog and saturating performance counters.
module hazard_ctrl_mc #(
  parameter int RA_W        = 5,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  Rs1D,
  input  logic [RA_W-1:0]  Rs2D,
  input  logic [RA_W-1:0]  Rs1E,
  input  logic [RA_W-1:0]  Rs2E,
  input  logic [RA_W-1:0]  RdE,
  input  logic [RA_W-1:0]  RdM,
  input  logic [RA_W-1:0]  RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE_b0,
  input  logic             PCSrcE,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             mdu_op_E,
  input  logic             mdu_done,
  output logic             mdu_go,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam int                WAIT_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WDOG_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic              WDOG_EN   = (WDOG_CYCLES != 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [RA_W-1:0]   REG_ZERO  = {RA_W{1'b0}};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              timeout_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              mem_stall_s;
  logic              lw_stall_s;
  logic              mdu_stall_s;
  logic              wdog_hit_s;
  logic              go_s;

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rd_m,
                                         input logic [RA_W-1:0] rd_w, input logic we_m,
                                         input logic we_w);
    logic [1:0] sel;
    if (we_m && (rd_m != REG_ZERO) && (rd_m == rs)) sel = 2'b10;
    else if (we_w && (rd_w != REG_ZERO) && (rd_w == rs)) sel = 2'b01;
    else sel = 2'b00;
    return sel;
  endfunction

  // The MDU stall releases in the done cycle so EX advances on the following edge.
  assign mem_stall_s = dmem_req & ~dmem_ack;
  assign lw_stall_s  = ResultSrcE_b0 & (RdE != REG_ZERO) & ((Rs1D == RdE) | (Rs2D == RdE));
  assign mdu_stall_s = ((state_r == ST_RUN) & mdu_op_E) | ((state_r == ST_BUSY) & ~mdu_done) |
                       ((state_r == ST_DONE) & mem_stall_s);
  assign wdog_hit_s  = WDOG_EN & mem_stall_s & (wait_cnt_r == WAIT_LAST) & (state_r != ST_ERR);
  assign go_s        = (state_r == ST_RUN) & mdu_op_E & ~mem_stall_s;
  assign mdu_go      = go_s & rst;
  assign ForwardAE   = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
  assign ForwardBE   = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
  assign dmem_timeout = timeout_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

  // Prioritised stall/flush selection: error, memory wait, MDU, then normal hazards.
  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    if (state_r == ST_ERR) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
    end else if (mem_stall_s) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mdu_stall_s) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = lw_stall_s;
      StallD = lw_stall_s;
      FlushD = PCSrcE;
      FlushE = lw_stall_s | PCSrcE;
    end
  end

  // Controller next state; a watchdog expiry overrides any MDU transition.
  always_comb begin
    state_nxt_s = state_r;
    if (wdog_hit_s) begin
      state_nxt_s = ST_ERR;
    end else begin
      case (state_r)
        ST_RUN:  state_nxt_s = (mdu_op_E && !mem_stall_s) ? ST_BUSY : ST_RUN;
        ST_BUSY: state_nxt_s = mdu_done ? (mem_stall_s ? ST_DONE : ST_RUN) : ST_BUSY;
        ST_DONE: state_nxt_s = mem_stall_s ? ST_DONE : ST_RUN;
        ST_ERR:  state_nxt_s = ST_ERR;
        default: state_nxt_s = ST_ERR;
      endcase
    end
  end

  // State, watchdog and counter registers; everything freezes once in ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      timeout_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_ERR) wait_cnt_r <= wait_cnt_r;
      else if (!mem_stall_s) wait_cnt_r <= {WAIT_W{1'b0}};
      else if (wait_cnt_r != WAIT_MAX) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      else wait_cnt_r <= wait_cnt_r;
      if (wdog_hit_s) timeout_r <= 1'b1;
      else timeout_r <= timeout_r;
      if ((state_r != ST_ERR) && StallF && (stall_cnt_r != CNT_MAX))
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      else stall_cnt_r <= stall_cnt_r;
      if ((state_r != ST_ERR) && FlushD && (flush_cnt_r != CNT_MAX))
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      else flush_cnt_r <= flush_cnt_r;
    end
  end

endmodule
